// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the lane-masked data memory.
// Holds the FSM encoding, default geometry and the lane-merge function.
package data_mem_pkg;

    localparam int DATA_W_DEF = 256;
    localparam int LANE_W_DEF = 16;
    localparam int DEPTH_DEF  = 6;
    localparam int ADDR_W_DEF = 3;

    // Widest word the merge helper handles; callers resize in and out of it.
    localparam int MAX_DATA_W = 4096;
    typedef logic [MAX_DATA_W-1:0] wide_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Bits set in bit_mask take new_w, the rest keep old_w.
    function automatic wide_t lane_merge(input wide_t old_w,
                                         input wide_t new_w,
                                         input wide_t bit_mask);
        return (old_w & ~bit_mask) | (new_w & bit_mask);
    endfunction

endpackage

// File: rtl/data_mem_lanes_if.sv
// Request/response bundle between the datapath and the lane-masked memory.
interface data_mem_lanes_if #(
    parameter int DATA_W = data_mem_pkg::DATA_W_DEF,
    parameter int LANE_W = data_mem_pkg::LANE_W_DEF,
    parameter int ADDR_W = data_mem_pkg::ADDR_W_DEF
);
    localparam int LANES = DATA_W / LANE_W;

    logic [ADDR_W-1:0] pointer;
    logic              write_data;
    logic              read_data;
    logic [DATA_W-1:0] data_to_write;
    logic [LANES-1:0]  lane_mask;
    logic              clear;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              addr_err;
    logic              busy;

    modport master (
        output pointer, write_data, read_data, data_to_write, lane_mask, clear,
        input  data, data_valid, addr_err, busy
    );

    modport slave (
        input  pointer, write_data, read_data, data_to_write, lane_mask, clear,
        output data, data_valid, addr_err, busy
    );

endinterface

// File: rtl/data_mem_clear_seq.sv
// Zero-sweep sequencer: walks every word index after reset or a clear request
// and reports busy while the sweep owns the array write port.
module data_mem_clear_seq
    import data_mem_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_CLEAR;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        clr_we    = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    state_nxt = ST_CLEAR;
                    idx_nxt   = '0;
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    assign busy     = (state == ST_CLEAR);
    assign clr_addr = idx;

endmodule

// File: rtl/data_mem_lanes.sv
// Lane-masked data memory: DEPTH x DATA_W array, registered read with valid
// strobe, out-of-range detection and a hardware zero sweep.
module data_mem_lanes
    import data_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int LANE_W = LANE_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic              clk,
    input logic              reset,
    data_mem_lanes_if.slave  bus
);

    localparam int LANES = DATA_W / LANE_W;

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              in_range;
    logic              accept;
    logic              wr_ok;
    logic              rd_req;
    logic              err_nxt;
    logic [DATA_W-1:0] bit_mask;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] merged;

    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [DEPTH];

    data_mem_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .clear    (bus.clear),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A clear request in idle drops any request presented alongside it.
    assign in_range = {1'b0, bus.pointer} < (ADDR_W + 1)'(DEPTH);
    assign accept   = !busy && !bus.clear;
    assign wr_ok    = accept && bus.write_data && in_range;
    assign rd_req   = accept && bus.read_data;
    assign err_nxt  = accept && (bus.write_data || bus.read_data) && !in_range;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign bit_mask[k*LANE_W +: LANE_W] = {LANE_W{bus.lane_mask[k]}};
    end

    assign rd_word = mem[bus.pointer];
    assign merged  = DATA_W'(lane_merge(wide_t'(rd_word),
                                        wide_t'(bus.data_to_write),
                                        wide_t'(bit_mask)));

    // NOTE: the array has no reset; the clear sweep zeroes it instead, which
    // keeps it mappable onto plain RAM without a reset network.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[bus.pointer] <= merged;
        end
    end

    // The read samples the array before this edge's write lands,
    // giving read-before-write on a shared pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= rd_req;
            err_q   <= err_nxt;
            if (rd_req) begin
                data_q <= in_range ? rd_word : '0;
            end
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = valid_q;
    assign bus.addr_err   = err_q;
    assign bus.busy       = busy;

endmodule

// File: tb/tb_data_mem_lanes.sv
// Directed bench for data_mem_lanes: sweep timing, lane masking,
// read-before-write, out-of-range handling, clear and mid-sweep reset.
module tb_data_mem_lanes;

    localparam int DW    = 256;
    localparam int DEPTH = 6;
    localparam int LW    = 16;
    localparam int AW    = 3;
    localparam int LANES = DW / LW;

    typedef logic [DW-1:0]    word_t;
    typedef logic [LANES-1:0] mask_t;

    localparam word_t ALL5 = {64{4'h5}};
    localparam word_t ALLA = {64{4'hA}};
    localparam word_t ALLF = {DW{1'b1}};
    localparam mask_t MFULL = {LANES{1'b1}};

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;
    word_t model [DEPTH];

    always #5 clk = ~clk;

    data_mem_lanes_if #(.DATA_W(DW), .LANE_W(LW), .ADDR_W(AW)) bus ();

    data_mem_lanes #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .LANE_W (LW),
        .ADDR_W (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pointer       = '0;
        bus.write_data    = 1'b0;
        bus.read_data     = 1'b0;
        bus.data_to_write = '0;
        bus.lane_mask     = '0;
        bus.clear         = 1'b0;
    endtask

    task automatic do_write(input int ptr, input word_t w, input mask_t m);
        bus.pointer       = AW'(ptr);
        bus.data_to_write = w;
        bus.lane_mask     = m;
        bus.write_data    = 1'b1;
        tick();
        bus.write_data    = 1'b0;
    endtask

    task automatic do_read(input int ptr, output word_t d, output logic v, output logic e);
        bus.pointer   = AW'(ptr);
        bus.read_data = 1'b1;
        tick();
        d = bus.data;
        v = bus.data_valid;
        e = bus.addr_err;
        bus.read_data = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        word_t d;
        logic  v, e;
        int    n;
        idle_inputs();
        reset = 1'b0;
        repeat (2) tick();
        n_total++;
        if ({bus.data, bus.data_valid, bus.addr_err, bus.busy} !== {word_t'(0), 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_state: got data=%h v=%b e=%b busy=%b, want 0/0/0/1",
                     bus.data, bus.data_valid, bus.addr_err, bus.busy);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        count_busy(n);
        n_total++;
        if (n !== DEPTH) $display("FAIL reset_sweep_len: got %0d cycles, want %0d", n, DEPTH);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            do_read(i, d, v, e);
            n_total++;
            if ({d, v, e} !== {word_t'(0), 1'b1, 1'b0})
                $display("FAIL post_reset_rd%0d: got data=%h v=%b e=%b, want 0/1/0", i, d, v, e);
            else n_pass++;
        end
        tick();
        n_total++;
        if (bus.data_valid !== 1'b0) $display("FAIL valid_pulse: got %b, want 0", bus.data_valid);
        else n_pass++;
    endtask

    task automatic test_write_full();
        word_t d;
        logic  v, e;
        do_write(2, ALL5, MFULL);
        model[2] = ALL5;
        do_read(2, d, v, e);
        n_total++;
        if ({d, v, e} !== {ALL5, 1'b1, 1'b0})
            $display("FAIL full_write: got data=%h v=%b e=%b, want %h/1/0", d, v, e, ALL5);
        else n_pass++;
        do_read(3, d, v, e);
        n_total++;
        if ({d, v, e} !== {word_t'(0), 1'b1, 1'b0})
            $display("FAIL neighbour_ptr3: got data=%h v=%b e=%b, want 0/1/0", d, v, e);
        else n_pass++;
    endtask

    task automatic test_lane_mask();
        word_t d, exp;
        logic  v, e;
        do_write(2, ALLA, mask_t'(16'h0001));
        exp = {ALL5[DW-1:16], 16'hAAAA};
        do_read(2, d, v, e);
        n_total++;
        if (d !== exp) $display("FAIL lane0_write: got %h, want %h", d, exp);
        else n_pass++;
        do_write(2, ALLF, '0);
        do_read(2, d, v, e);
        n_total++;
        if (d !== exp) $display("FAIL zero_mask_noop: got %h, want %h", d, exp);
        else n_pass++;
        do_write(2, ALLF, mask_t'(16'h8000));
        exp = {16'hFFFF, exp[DW-17:0]};
        do_read(2, d, v, e);
        n_total++;
        if (d !== exp) $display("FAIL lane15_write: got %h, want %h", d, exp);
        else n_pass++;
        model[2] = exp;
    endtask

    task automatic test_back_to_back();
        word_t d, prev, val;
        logic  v, e;
        prev = '0;
        for (int j = 0; j < 32; j++) begin
            val = word_t'(8'hAA) << (8 * j);
            bus.pointer       = AW'(4);
            bus.data_to_write = val;
            bus.lane_mask     = MFULL;
            bus.write_data    = 1'b1;
            bus.read_data     = 1'b1;
            tick();
            n_total++;
            if ({bus.data, bus.data_valid} !== {prev, 1'b1})
                $display("FAIL rbw_byte%0d: got data=%h v=%b, want %h/1", j, bus.data, bus.data_valid, prev);
            else n_pass++;
            prev = val;
        end
        bus.write_data = 1'b0;
        bus.read_data  = 1'b0;
        do_read(4, d, v, e);
        n_total++;
        if (d !== {8'hAA, 248'h0}) $display("FAIL walk_final: got %h, want %h", d, {8'hAA, 248'h0});
        else n_pass++;
        model[4] = d;
        tick();
        n_total++;
        if ({bus.data, bus.data_valid} !== {8'hAA, 248'h0, 1'b0})
            $display("FAIL data_hold: got data=%h v=%b, want %h/0", bus.data, bus.data_valid, {8'hAA, 248'h0});
        else n_pass++;
    endtask

    task automatic test_addr_err();
        word_t d;
        logic  v, e;
        do_read(7, d, v, e);
        n_total++;
        if ({d, v, e} !== {word_t'(0), 1'b1, 1'b1})
            $display("FAIL oor_read: got data=%h v=%b e=%b, want 0/1/1", d, v, e);
        else n_pass++;
        tick();
        n_total++;
        if ({bus.data_valid, bus.addr_err} !== 2'b00)
            $display("FAIL err_pulse: got v=%b e=%b, want 0/0", bus.data_valid, bus.addr_err);
        else n_pass++;
        do_write(6, ALLF, MFULL);
        n_total++;
        if ({bus.data_valid, bus.addr_err} !== 2'b01)
            $display("FAIL oor_write: got v=%b e=%b, want 0/1", bus.data_valid, bus.addr_err);
        else n_pass++;
        bus.pointer = AW'(7);
        tick();
        n_total++;
        if (bus.addr_err !== 1'b0) $display("FAIL no_strobe_err: got %b, want 0", bus.addr_err);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            do_read(i, d, v, e);
            n_total++;
            if (d !== model[i]) $display("FAIL oor_untouched%0d: got %h, want %h", i, d, model[i]);
            else n_pass++;
        end
    endtask

    task automatic test_clear();
        word_t d;
        logic  v, e;
        int    n;
        do_write(0, ALLF, MFULL);
        do_read(0, d, v, e);
        bus.clear         = 1'b1;
        bus.pointer       = AW'(1);
        bus.data_to_write = ALL5;
        bus.lane_mask     = MFULL;
        bus.write_data    = 1'b1;
        bus.read_data     = 1'b1;
        tick();
        bus.clear      = 1'b0;
        bus.write_data = 1'b0;
        n_total++;
        if ({bus.busy, bus.data_valid, bus.data} !== {1'b1, 1'b0, ALLF})
            $display("FAIL clear_drop: got busy=%b v=%b data=%h, want 1/0/%h",
                     bus.busy, bus.data_valid, bus.data, ALLF);
        else n_pass++;
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            tick();
            n++;
            n_total++;
            if ({bus.data_valid, bus.data} !== {1'b0, ALLF})
                $display("FAIL sweep_ignore%0d: got v=%b data=%h, want 0/%h", n, bus.data_valid, bus.data, ALLF);
            else n_pass++;
        end
        bus.read_data = 1'b0;
        n_total++;
        if (n !== DEPTH) $display("FAIL clear_sweep_len: got %0d cycles, want %0d", n, DEPTH);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            do_read(i, d, v, e);
            model[i] = '0;
            n_total++;
            if (d !== '0) $display("FAIL cleared_rd%0d: got %h, want 0", i, d);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_sweep();
        word_t d;
        logic  v, e;
        int    n;
        do_write(5, ALL5, MFULL);
        do_read(5, d, v, e);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        #2;
        n_total++;
        if ({bus.busy, bus.data_valid, bus.data} !== {1'b1, 1'b0, word_t'(0)})
            $display("FAIL mid_sweep_reset: got busy=%b v=%b data=%h, want 1/0/0",
                     bus.busy, bus.data_valid, bus.data);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        count_busy(n);
        n_total++;
        if (n !== DEPTH) $display("FAIL restart_sweep_len: got %0d cycles, want %0d", n, DEPTH);
        else n_pass++;
        do_read(5, d, v, e);
        n_total++;
        if ({d, v} !== {word_t'(0), 1'b1}) $display("FAIL restart_rd5: got data=%h v=%b, want 0/1", d, v);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        test_reset();
        test_write_full();
        test_lane_mask();
        test_back_to_back();
        test_addr_err();
        test_clear();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_mem_lanes.md
Name: data_mem_lanes

Overview:
Parametrised next-generation data memory for the CPU datapath: DEPTH words of DATA_W bits with per-lane write masking, registered synchronous read with a valid strobe, and out-of-range address detection. Includes a hardware clear sequencer that zeroes every word after reset or on request. Sits between the execute stage and the register/matrix units, replacing the fixed 6x256 memory.

Parameters:
DATA_W, 256, word width in bits; must be a multiple of LANE_W.
DEPTH, 6, number of words; minimum 2.
LANE_W, 16, write-mask granularity in bits; LANES = DATA_W/LANE_W.
ADDR_W, 3, pointer width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
pointer  in  ADDR_W  word address for read/write
write_data  in  1  write strobe, sampled on the rising edge
read_data  in  1  read strobe, sampled on the rising edge
data_to_write  in  DATA_W  write data
lane_mask  in  LANES  bit k=1 enables write of bits [k*LANE_W +: LANE_W]
clear  in  1  request full-memory zero sweep
data  out  DATA_W  registered read data
data_valid  out  1  one-cycle pulse: data updated this cycle
addr_err  out  1  one-cycle pulse: last accepted request had pointer >= DEPTH
busy  out  1  high while clear sweep runs; requests ignored

Behaviour:
- Reset asserted (low): data=0, data_valid=0, addr_err=0, busy=1, state=CLEAR, sweep index=0. Memory array is not reset directly.
- FSM states: CLEAR, IDLE.
- CLEAR: each edge writes all-zero to mem[index], index++; at the edge writing index DEPTH-1 -> IDLE, busy=0 from that edge. Sweep lasts exactly DEPTH cycles after reset release.
- In CLEAR: write_data, read_data, and clear are ignored; data_valid and addr_err stay 0; data holds.
- IDLE, clear=1: go to CLEAR next edge, index=0, busy=1. Any same-cycle write/read is dropped.
- IDLE write (write_data=1, pointer<DEPTH): lanes with lane_mask bit set take data_to_write at that edge; other lanes keep old value. lane_mask=0 is a legal no-op write.
- IDLE read (read_data=1, pointer<DEPTH): data <= mem[pointer] at that edge; data_valid=1 for exactly that cycle. Latency: one edge.
- Read and write on the same pointer in the same cycle: read returns pre-write contents (read-before-write); write still takes effect.
- Read and write on different pointers in the same cycle: both serviced.
- pointer >= DEPTH with write or read strobe: write dropped; read returns data=0 with data_valid=1; addr_err=1 for that cycle. No strobe means no error.
- No read: data holds its last value; data_valid=0.
- Reset asserted mid-sweep or mid-operation: immediate return to reset values; the sweep restarts from index 0 on release.
- Strobes are level-sampled; holding one high for N cycles performs N operations.

Decomposition:
- Package data_mem_pkg: state encoding (ST_CLEAR, ST_IDLE), default DATA_W/LANE_W/DEPTH constants, and a function for the lane-mask merge (old, new, mask).
- Sub-module data_mem_clear_seq: sweep counter and FSM; outputs busy, clr_we, clr_addr. The top holds the array, port muxing, and output registers.

Test Plan:
- Reset release -> busy=1 for 6 cycles, then 0; reading pointers 0..5 returns 0 with data_valid pulses and addr_err=0.
- Write 0x5555...5 to ptr 2 with mask all-ones, then read ptr 2 -> data=0x5555...5 one edge later, data_valid pulse; ptr 3 still reads 0.
- Write 0xAAAA...A to ptr 2 with lane_mask=0x0001 -> read gives upper 240 bits 0x5555..., lowest 16 bits 0xAAAA.
- Same-cycle write 0xAA to ptr 4 and read ptr 4 -> data returns old value 0; a following read returns 0xAA. Walk 0xAA across 32 byte positions by repeated x256 shifts; each readback must match.
- Read ptr 7 -> data=0, data_valid=1, addr_err=1; write ptr 6 -> addr_err=1 and no array word changes.
- After nonzero writes, pulse clear with a same-cycle write -> write dropped, busy for 6 cycles, all words read 0. Assert reset in sweep cycle 3 -> sweep restarts for a full 6 cycles.
